// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: shares one in-order read port between two requesters with a tag FIFO for return routing.
// Ties are round-robin by default; define ROM_ARB_STRICT_PRIORITY_EN to make requester 0 always win.
module rom_read_arbiter #(
  parameter int ADDR_WIDTH      = 11,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  readclk0,
  input  logic [ADDR_WIDTH-1:0] raddr0,
  output logic                  rdy0,
  output logic                  outclk0,
  input  logic                  readclk1,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic                  rdy1,
  output logic                  outclk1,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  ram_readclk,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic                  ram_outclk,
  input  logic [DATA_WIDTH-1:0] ram_out,
  output logic                  err
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic [PW:0] FULL = (PW+1)'(MAX_OUTSTANDING);
  logic [1:0] pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] paddr0_q, paddr0_d, paddr1_q, paddr1_d, raddr_q, raddr_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic rdclk_q, rdclk_d, oc0_q, oc0_d, oc1_q, oc1_d, err_q, err_d;
  logic tie, g, issue, pop, head;
`ifdef ROM_ARB_STRICT_PRIORITY_EN
  assign tie = 1'b0;
`else
  logic last_q;
  always_ff @(posedge clk) last_q <= rst ? 1'b1 : issue ? g : last_q;
  assign tie = !last_q;
`endif
  // a pop in the same cycle frees a slot, so a full FIFO can still accept one issue
  always_comb begin
    g = pend_q[0] ? (pend_q[1] & tie) : 1'b1;
    issue = |pend_q && (cnt_q != FULL || ram_outclk);
    pop = ram_outclk && cnt_q != '0;
    head = tag_q[rptr_q];
    pend_d[0] = (pend_q[0] && !(issue && !g)) || (readclk0 && !pend_q[0]);
    pend_d[1] = (pend_q[1] && !(issue && g)) || (readclk1 && !pend_q[1]);
    paddr0_d = (readclk0 && !pend_q[0]) ? raddr0 : paddr0_q;
    paddr1_d = (readclk1 && !pend_q[1]) ? raddr1 : paddr1_q;
    rdclk_d = issue;
    raddr_d = issue ? (g ? paddr1_q : paddr0_q) : raddr_q;
    tag_d = tag_q;
    if (issue) tag_d[wptr_q] = g;
    wptr_d = wptr_q + PW'(issue);
    rptr_d = rptr_q + PW'(pop);
    cnt_d = cnt_q + (PW+1)'(issue) - (PW+1)'(pop);
    oc0_d = pop && !head;
    oc1_d = pop && head;
    out_d = pop ? ram_out : out_q;
    err_d = err_q || (ram_outclk && cnt_q == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      paddr0_q <= '0;
      paddr1_q <= '0;
      rdclk_q <= 1'b0;
      raddr_q <= '0;
      tag_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      oc0_q <= 1'b0;
      oc1_q <= 1'b0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      paddr0_q <= paddr0_d;
      paddr1_q <= paddr1_d;
      rdclk_q <= rdclk_d;
      raddr_q <= raddr_d;
      tag_q <= tag_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      oc0_q <= oc0_d;
      oc1_q <= oc1_d;
      out_q <= out_d;
      err_q <= err_d;
    end
  end
  assign rdy0 = !pend_q[0];
  assign rdy1 = !pend_q[1];
  assign ram_readclk = rdclk_q;
  assign ram_raddr = raddr_q;
  assign outclk0 = oc0_q;
  assign outclk1 = oc1_q;
  assign out = out_q;
  assign err = err_q;
endmodule
